// File: rtl/draw_bouncing_rect.sv
`default_nettype none
// ============================================================================
// Module   : draw_bouncing_rect
// Purpose  : Pixel-pipeline overlay stage. Draws a solid RECT_W x RECT_H
//            rectangle of RECT_COLOR over the incoming RGB stream. The
//            rectangle moves by STEP_X/STEP_Y once per frame (at the vblank
//            rising edge) and bounces off the edges of the active area.
//            Timing signals are re-emitted with the same 2-cycle latency as
//            the RGB path so further overlay stages can be chained.
// Ports    : pclk, rst (async, active-high)
//            enable                    - 1 = motion enabled, 0 = frozen
//            hcount_in/vcount_in [10:0] - pixel / line counters
//            hsync_in, vsync_in, hblnk_in, vblnk_in - timing strobes
//            rgb_in [11:0]             - background pixel (4:4:4)
//            hcount_out ... vblnk_out  - timing inputs delayed 2 cycles
//            rgb_out [11:0]            - composited pixel, aligned to *_out
//            xpos_out/ypos_out [10:0]  - rectangle top-left position
// Revision : 1.0 - initial release
// ============================================================================
module draw_bouncing_rect #(
  parameter int          RECT_W     = 64,
  parameter int          RECT_H     = 48,
  parameter logic [11:0] RECT_COLOR = 12'hF_8_0,
  parameter int          STEP_X     = 4,
  parameter int          STEP_Y     = 2,
  parameter int          H_ACTIVE   = 1280,
  parameter int          V_ACTIVE   = 720
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        enable,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic [10:0] xpos_out,
  output logic [10:0] ypos_out
);

  // All position arithmetic is done at 12 bits so x+RECT_W etc. cannot wrap.
  localparam logic [11:0] c_rect_w = 12'(RECT_W);
  localparam logic [11:0] c_rect_h = 12'(RECT_H);
  localparam logic [11:0] c_step_x = 12'(STEP_X);
  localparam logic [11:0] c_step_y = 12'(STEP_Y);
  localparam logic [11:0] c_x_max  = 12'(H_ACTIVE - RECT_W);
  localparam logic [11:0] c_y_max  = 12'(V_ACTIVE - RECT_H);

  // Direction FSM encodings
  localparam logic [0:0] c_right = 1'b0;
  localparam logic [0:0] c_left  = 1'b1;
  localparam logic [0:0] c_down  = 1'b0;
  localparam logic [0:0] c_up    = 1'b1;

  // Position / direction state
  logic [10:0] r_x;
  logic [10:0] r_y;
  logic [0:0]  r_dir_x;
  logic [0:0]  r_dir_y;
  logic        r_vblnk_d;

  // Stage-1 pipeline registers
  logic [10:0] r_hcount_s1;
  logic [10:0] r_vcount_s1;
  logic        r_hsync_s1;
  logic        r_vsync_s1;
  logic        r_hblnk_s1;
  logic        r_vblnk_s1;
  logic [11:0] r_rgb_s1;
  logic        r_inside;

  logic [11:0] w_x12;
  logic [11:0] w_y12;
  logic [11:0] w_h12;
  logic [11:0] w_v12;
  logic        w_inside;
  logic        w_frame_tick;
  logic [10:0] w_x_nxt;
  logic [10:0] w_y_nxt;
  logic [0:0]  w_dir_x_nxt;
  logic [0:0]  w_dir_y_nxt;

  assign w_x12 = {1'b0, r_x};
  assign w_y12 = {1'b0, r_y};
  assign w_h12 = {1'b0, hcount_in};
  assign w_v12 = {1'b0, vcount_in};

  // Hit test uses the live counters so edges land exactly on x..x+RECT_W-1.
  assign w_inside = (w_h12 >= w_x12) && (w_h12 < (w_x12 + c_rect_w)) &&
                    (w_v12 >= w_y12) && (w_v12 < (w_y12 + c_rect_h));

  // One-cycle pulse on the vblank rising edge; position moves only here,
  // i.e. outside the visible region, so a frame can never tear.
  assign w_frame_tick = vblnk_in && !r_vblnk_d;

  // Horizontal bounce FSM
  always_comb begin
    w_x_nxt     = r_x;
    w_dir_x_nxt = r_dir_x;
    case (r_dir_x)
      c_right: begin
        if ((w_x12 + c_step_x) >= c_x_max) begin
          w_x_nxt     = c_x_max[10:0];
          w_dir_x_nxt = c_left;
        end else begin
          w_x_nxt = r_x + c_step_x[10:0];
        end
      end
      c_left: begin
        if (w_x12 <= c_step_x) begin
          w_x_nxt     = 11'd0;
          w_dir_x_nxt = c_right;
        end else begin
          w_x_nxt = r_x - c_step_x[10:0];
        end
      end
      default: begin
        w_x_nxt     = r_x;
        w_dir_x_nxt = r_dir_x;
      end
    endcase
  end

  // Vertical bounce FSM
  always_comb begin
    w_y_nxt     = r_y;
    w_dir_y_nxt = r_dir_y;
    case (r_dir_y)
      c_down: begin
        if ((w_y12 + c_step_y) >= c_y_max) begin
          w_y_nxt     = c_y_max[10:0];
          w_dir_y_nxt = c_up;
        end else begin
          w_y_nxt = r_y + c_step_y[10:0];
        end
      end
      c_up: begin
        if (w_y12 <= c_step_y) begin
          w_y_nxt     = 11'd0;
          w_dir_y_nxt = c_down;
        end else begin
          w_y_nxt = r_y - c_step_y[10:0];
        end
      end
      default: begin
        w_y_nxt     = r_y;
        w_dir_y_nxt = r_dir_y;
      end
    endcase
  end

  // Position state and frame-start detector
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_x       <= 11'd0;
      r_y       <= 11'd0;
      r_dir_x   <= c_right;
      r_dir_y   <= c_down;
      r_vblnk_d <= 1'b0;
    end else begin
      r_vblnk_d <= vblnk_in;
      if (w_frame_tick && enable) begin
        r_x     <= w_x_nxt;
        r_y     <= w_y_nxt;
        r_dir_x <= w_dir_x_nxt;
        r_dir_y <= w_dir_y_nxt;
      end
    end
  end

  // Stage 1: register timing, background pixel and the hit-test result
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_hcount_s1 <= 11'd0;
      r_vcount_s1 <= 11'd0;
      r_hsync_s1  <= 1'b0;
      r_vsync_s1  <= 1'b0;
      r_hblnk_s1  <= 1'b0;
      r_vblnk_s1  <= 1'b0;
      r_rgb_s1    <= 12'h000;
      r_inside    <= 1'b0;
    end else begin
      r_hcount_s1 <= hcount_in;
      r_vcount_s1 <= vcount_in;
      r_hsync_s1  <= hsync_in;
      r_vsync_s1  <= vsync_in;
      r_hblnk_s1  <= hblnk_in;
      r_vblnk_s1  <= vblnk_in;
      r_rgb_s1    <= rgb_in;
      r_inside    <= w_inside;
    end
  end

  // Stage 2: composite; blanking forces black regardless of the overlay
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_out <= 11'd0;
      vcount_out <= 11'd0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= 12'h000;
    end else begin
      hcount_out <= r_hcount_s1;
      vcount_out <= r_vcount_s1;
      hsync_out  <= r_hsync_s1;
      vsync_out  <= r_vsync_s1;
      hblnk_out  <= r_hblnk_s1;
      vblnk_out  <= r_vblnk_s1;
      if (r_hblnk_s1 || r_vblnk_s1) begin
        rgb_out <= 12'h000;
      end else if (r_inside) begin
        rgb_out <= RECT_COLOR;
      end else begin
        rgb_out <= r_rgb_s1;
      end
    end
  end

  assign xpos_out = r_x;
  assign ypos_out = r_y;

endmodule
`default_nettype wire

// File: doc/draw_bouncing_rect.md
# draw_bouncing_rect

Pixel-pipeline stage directly downstream of the 1280x720 video timing generator (1650x750 total, pclk). It consumes hcount/vcount, sync and blank signals plus an incoming RGB stream. It overlays a solid rectangle whose position advances once per frame, bouncing off the active-area edges. Timing signals are re-emitted delayed to match the RGB path, so further overlay stages can be chained.

## Interface
Parameters:
- RECT_W, 64: rectangle width in pixels.
- RECT_H, 48: rectangle height in lines.
- RECT_COLOR, 12'hF_8_0: overlay colour, 4:4:4 RGB.
- STEP_X, 4: horizontal move per frame.
- STEP_Y, 2: vertical move per frame.
- H_ACTIVE, 1280: active pixels per line.
- V_ACTIVE, 720: active lines per frame.

Constraints: RECT_W+STEP_X <= H_ACTIVE; RECT_H+STEP_Y <= V_ACTIVE; STEP_X, STEP_Y >= 1.

Ports (reset rst, asynchronous, active-high; clock pclk):
- pclk  in  1  pixel clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = motion enabled, 0 = position frozen.
- hcount_in, vcount_in  in  11 each  pixel and line counters from timing.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing strobes.
- rgb_in  in  12  background pixel.
- hcount_out, vcount_out  out  11 each  inputs delayed 2 cycles.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  inputs delayed 2 cycles.
- rgb_out  out  12  composited pixel, aligned with the *_out timing.
- xpos_out, ypos_out  out  11 each  current rectangle top-left position.

## Operation
- Pipeline stage 1 registers all timing inputs and rgb_in. It also registers `inside`:
  - inside = (hcount_in >= x) && (hcount_in < x+RECT_W) && (vcount_in >= y) && (vcount_in < y+RECT_H).
  - Compares are 12-bit unsigned, so the sums cannot overflow.
- Pipeline stage 2:
  - If stage-1 hblnk or vblnk is set, rgb_out = 12'h000.
  - Else if inside, rgb_out = RECT_COLOR.
  - Else rgb_out = stage-1 rgb.
  - Timing signals pass through unchanged.
- Frame-start detect:
  - vblnk_d holds the previous vblnk_in.
  - frame_tick = vblnk_in && !vblnk_d, a single-cycle pulse on the vblank rising edge.
- Position update happens only on frame_tick with enable=1. Otherwise x, y, dir_x and dir_y hold.
- Because updates occur only inside vblank, no tearing is possible within a visible frame.
- Horizontal direction FSM, states RIGHT and LEFT:
  - RIGHT: if x+STEP_X >= H_ACTIVE-RECT_W, then x <= H_ACTIVE-RECT_W and the state goes to LEFT. Else x <= x+STEP_X.
  - LEFT: if x <= STEP_X, then x <= 0 and the state goes to RIGHT. Else x <= x-STEP_X.
- Vertical direction FSM, states DOWN and UP: identical rules using y, STEP_Y, RECT_H and V_ACTIVE.
- Both axes update on the same frame_tick and are independent. A corner hit flips both directions.
- xpos_out and ypos_out are the x and y registers directly.

## Timing
- Latency is exactly 2 pclk cycles from any input to the corresponding output. The overlay decision uses the same-cycle hcount_in/vcount_in, so the rectangle edges land exactly on pixels x..x+RECT_W-1.
- Position registers change in the cycle after frame_tick is sampled. That change is visible in the pipeline starting with the next frame's active pixels.
- Reset, asynchronous and taking effect immediately, including mid-line or mid-frame:
  - All *_out = 0 and rgb_out = 0.
  - x = 0, y = 0, dir_x = RIGHT, dir_y = DOWN, vblnk_d = 0, inside = 0.
- First edge after reset release:
  - vblnk_d starts at 0, so a high vblnk_in on the first edge produces a frame_tick.
  - This is intended: the first move occurs at the first observed vblank.
- If enable deasserts between ticks, the next tick is ignored. The position resumes on the first tick seen with enable=1, and no ticks are queued.

## Test plan
- Reset check: assert rst mid-frame with random inputs, then confirm that all outputs are 0 immediately (asynchronously). Release rst, then after the first vblank rising edge with enable=1 confirm xpos_out=4 and ypos_out=2.
- Latency and overlay check: hold x=0, y=0 (enable=0), rgb_in=12'h0F0, and run one frame. Then confirm:
  - rgb_out=12'hF80 for hcount_out 0..63 and vcount_out 0..47;
  - rgb_out=12'h0F0 at hcount_out=64;
  - every *_out equals its input delayed exactly 2 cycles.
- Blanking check: hblnk_in=1 with rgb_in=12'hFFF over the rectangle area -> rgb_out=12'h000 two cycles later.
- Right and left bounce on x:
  - Starting at x=1208 moving RIGHT, successive ticks give 1212, 1216 (state becomes LEFT), then 1212.
  - Starting at x=8 moving LEFT, ticks give 4, 0 (state becomes RIGHT), then 4.
- Vertical bounce on y: starting at y=668 moving DOWN, ticks give 670, 672 (state becomes UP), then 670. A corner case with x=1216 and y=672 reached on the same tick flips both directions at once.
- Enable gating: with enable=0 across 3 vblank edges, xpos and ypos stay unchanged. Raising enable mid-frame produces exactly one step at the next vblank rising edge.
